// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the fifo write-side (and later read-side)
// schedulers.
//   arb_state_t        - arbiter FSM encoding (ST_IDLE / ST_BURST)
//   DEFAULT_DATA_WIDTH - default fifo word width
//   MAX_PORTS          - widest one-hot vector onehot_to_idx accepts
//   onehot_to_idx()    - converts a one-hot owner vector into an index
package fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int MAX_PORTS          = 8;

  // OR-reduction of the set bit positions. For a true one-hot input this is
  // the index of the set bit; an all-zero input maps to 0.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority picker.
// Searches req upward starting at ptr+1 (wrapping) and returns the first
// asserted line, so the line at ptr itself has the lowest priority.
//   req    in  N      request vector
//   ptr    in  IDX_W  last served index
//   found  out 1      at least one request is set
//   winner out IDX_W  selected index (0 when found is low)
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  int cand;

  // Walk the offsets from farthest to nearest; the nearest hit is written
  // last and therefore wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int off = N; off >= 1; off--) begin
      cand = (int'(ptr) + off) % N;
      if (req[cand]) begin
        found  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of the fifo write port.
// Grants one producer at a time for a burst of at most MAX_BURST words,
// forwards accepted words as registered fifo_wr_req/fifo_data and stalls
// while fifo_almost_full is high.
//   clk, rst_n        clock (fifo wr_clk), async active-low reset
//   en                arbitration enable
//   req_valid/last    per-producer word available / end-of-packet
//   req_data          packed producer words, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack           combinational pop strobe to the granted producer
//   grant             registered one-hot owner, zero when idle
//   fifo_almost_full  throttle from the fifo
//   fifo_wr_req       registered write strobe
//   fifo_data         registered write word
//   busy              high while a burst is owned
//   state_dbg         current FSM state
//
// Producer handshake: a word transfers on a rising edge where req_valid[i]
// and req_ack[i] are both high. A producer holds req_data/req_last stable
// while req_valid is high and unacked; req_ack may depend combinationally on
// req_valid but req_valid must never depend on req_ack.
//
// Because a write lands one clock after its ack, the fifo almost_full
// threshold has to sit at least two entries below full.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_BURST  = 8,
  parameter int CNT_BITS   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_req,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          busy,
  output arb_state_t                    state_dbg
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t            state;
  logic [CNT_BITS-1:0]   beat_cnt;
  logic [IDX_W-1:0]      rr_ptr;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;

  logic [IDX_W-1:0]      g_idx;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  accept;
  logic [CNT_BITS-1:0]   beat_nxt;
  logic                  end_burst;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .found  (pick_found),
    .winner (pick_idx)
  );

  // The owner index is recovered from the registered one-hot grant so the
  // two can never disagree.
  assign g_idx   = IDX_W'(onehot_to_idx(MAX_PORTS'(grant)));
  assign g_valid = req_valid[g_idx];
  assign g_last  = req_last[g_idx];
  assign g_data  = req_data[g_idx*DATA_WIDTH +: DATA_WIDTH];

  // en low blocks the accept too, so a burst stopped by en never writes in
  // its final cycle.
  assign accept    = (state == ST_BURST) && en && g_valid && !fifo_almost_full;
  assign req_ack   = accept ? grant : '0;
  assign beat_nxt  = beat_cnt + CNT_BITS'(1);
  // Last beat and MAX_BURST in the same cycle collapse into one exit.
  assign end_burst = g_last || (beat_nxt == CNT_BITS'(MAX_BURST));

  assign busy      = (state == ST_BURST);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      fifo_wr_req <= 1'b0;
      fifo_data   <= '0;
      beat_cnt    <= '0;
      // Starting at the top index gives producer 0 first priority.
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          fifo_wr_req <= 1'b0;
          if (en && pick_found && !fifo_almost_full) begin
            grant    <= NUM_REQ'(1) << pick_idx;
            beat_cnt <= '0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          fifo_wr_req <= accept;
          if (accept) begin
            fifo_data <= g_data;
            beat_cnt  <= beat_nxt;
          end
          // almost_full with a valid owner falls through here: a stall
          // that keeps the grant and the beat count.
          if (!en || !g_valid || (accept && end_burst)) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= g_idx;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
